rs_tick_ctrl: RTL and testbench

Bus-mapped tick sequencer and I/O port for the redstone core. It replaces the free-running PLL tick with a programmable divider that supports free-run, N-step and single-step modes. It exposes the core's input and output vectors as 16-bit EBAB slave registers. It sits between the EBAB bridge, the board switches and the `redstone` instance.

---
 rtl/rs_tick_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_rs_tick_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_tick_ctrl.sv
// rs_tick_ctrl: bus-mapped tick sequencer and I/O port for the redstone core.
//   Programmable divider for free-run / N-step / single-step ticking, a 32-bit
//   tick counter, a selectable input vector and output captures, all exposed
//   as 16-bit EBAB slave registers.
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   ebab_*                  EBAB slave (word index = ebab_address[5:1])
//   i_switches              async board inputs (synchronised here)
//   i_rs_outputs            redstone outputs, captured after each tick
//   o_rs_inputs             registered redstone inputs
//   o_tick                  one-cycle tick enable to the core
module rs_tick_ctrl #(
  parameter int          N_IN      = 10,
  parameter int          N_OUT     = 10,
  parameter logic [31:0] DIV_RESET = 32'd4999999
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [29:0]      ebab_address,
  input  logic [1:0]       ebab_byte_enable,
  input  logic             ebab_read,
  input  logic             ebab_write,
  input  logic [15:0]      ebab_write_data,
  output logic             ebab_acknowledge,
  output logic [15:0]      ebab_read_data,
  input  logic [N_IN-1:0]  i_switches,
  input  logic [N_OUT-1:0] i_rs_outputs,
  output logic [N_IN-1:0]  o_rs_inputs,
  output logic             o_tick
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

  state_t            r_state, w_next;
  logic              r_run, r_src;
  logic [31:0]       r_div, r_cnt, r_ticks;
  logic [15:0]       r_step, w_step_nxt;
  logic [N_IN-1:0]   r_in, r_sw1, r_sw2, r_rs_in;
  logic [N_OUT-1:0]  r_out;
  logic              r_tick_d;

  logic [4:0]  w_idx;
  logic        w_ack, w_wr, w_rd;
  logic        w_wr_ctrl, w_wr_divlo, w_wr_divhi, w_wr_step, w_wr_in;
  logic        w_step_pulse, w_active, w_tick, w_dec;
  logic [63:0] w_in_pad, w_out_pad, w_in_wr;
  logic [15:0] w_rdata, w_step_tmp;

  // Address bits outside the word index are decoded externally.
  wire w_unused = &{1'b0, ebab_address[29:6], ebab_address[0]};

  function automatic logic [15:0] merge(input logic [15:0] old,
                                        input logic [15:0] wd,
                                        input logic [1:0]  be);
    merge = old;
    if (be[0]) merge[7:0]  = wd[7:0];
    if (be[1]) merge[15:8] = wd[15:8];
  endfunction

  // ---------------- EBAB slave FSM ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ebab_read || ebab_write) w_next = S_ACK;
      S_ACK:   w_next = S_WAIT;
      // Hold here until the master releases its strobe so it is acked once.
      S_WAIT:  if (!ebab_read && !ebab_write) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_idx = ebab_address[5:1];
  assign w_ack = (r_state == S_ACK);
  assign w_wr  = w_ack && ebab_write;
  assign w_rd  = w_ack && ebab_read && !ebab_write;   // write wins

  assign w_wr_ctrl  = w_wr && (w_idx == 5'd0);
  assign w_wr_divlo = w_wr && (w_idx == 5'd2);
  assign w_wr_divhi = w_wr && (w_idx == 5'd3);
  assign w_wr_step  = w_wr && (w_idx == 5'd4);
  assign w_wr_in    = w_wr && (w_idx[4:2] == 3'b010);

  assign w_step_pulse = w_wr_ctrl && ebab_byte_enable[0] && ebab_write_data[1];

  // ---------------- divider / step logic ----------------
  assign w_active = r_run || (r_step != 16'd0);
  assign w_tick   = w_active && (r_cnt == r_div);
  assign w_dec    = w_tick && !r_run;   // RUN freezes the step count

  always_comb begin
    w_step_tmp = r_step - {15'd0, w_dec};
    if (w_step_pulse && (w_step_tmp != 16'hFFFF)) w_step_tmp = w_step_tmp + 16'd1;
    w_step_nxt = w_step_tmp;
    if (w_wr_step) w_step_nxt = merge(r_step, ebab_write_data, ebab_byte_enable);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_run    <= 1'b0;
      r_src    <= 1'b0;
      r_div    <= DIV_RESET;
      r_cnt    <= 32'd0;
      r_step   <= 16'd0;
      r_ticks  <= 32'd0;
      r_tick_d <= 1'b0;
      r_out    <= '0;
    end else begin
      if (w_wr_ctrl && ebab_byte_enable[0]) begin
        r_run <= ebab_write_data[0];
        r_src <= ebab_write_data[2];
      end
      if (w_wr_divlo) r_div[15:0]  <= merge(r_div[15:0],  ebab_write_data, ebab_byte_enable);
      if (w_wr_divhi) r_div[31:16] <= merge(r_div[31:16], ebab_write_data, ebab_byte_enable);

      if (w_wr_divlo || w_wr_divhi || !w_active || w_tick) r_cnt <= 32'd0;
      else                                                 r_cnt <= r_cnt + 32'd1;

      r_step   <= w_step_nxt;
      r_ticks  <= r_ticks + {31'd0, w_tick};
      // Capture one cycle after the tick, once the core has updated.
      r_tick_d <= w_tick;
      if (r_tick_d) r_out <= i_rs_outputs;
    end
  end

  assign o_tick = w_tick;

  // ---------------- input path ----------------
  always_comb begin
    w_in_pad  = '0;
    w_in_pad[N_IN-1:0] = r_in;
    w_out_pad = '0;
    w_out_pad[N_OUT-1:0] = r_out;
    w_in_wr   = w_in_pad;
    if (w_wr_in)
      w_in_wr[{w_idx[1:0], 4'b0000} +: 16] =
        merge(w_in_pad[{w_idx[1:0], 4'b0000} +: 16], ebab_write_data, ebab_byte_enable);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_in    <= '0;
      r_sw1   <= '0;
      r_sw2   <= '0;
      r_rs_in <= '0;
    end else begin
      r_in    <= w_in_wr[N_IN-1:0];
      r_sw1   <= i_switches;
      r_sw2   <= r_sw1;
      r_rs_in <= r_src ? r_in : r_sw2;
    end
  end

  assign o_rs_inputs = r_rs_in;

  // ---------------- read mux ----------------
  always_comb begin
    w_rdata = 16'd0;
    if (w_rd) begin
      case (w_idx)
        5'd0:  w_rdata = {13'd0, r_src, 1'b0, r_run};
        5'd1:  w_rdata = {14'd0, (r_step != 16'd0), w_active};
        5'd2:  w_rdata = r_div[15:0];
        5'd3:  w_rdata = r_div[31:16];
        5'd4:  w_rdata = r_step;
        5'd5:  w_rdata = r_ticks[15:0];
        5'd6:  w_rdata = r_ticks[31:16];
        5'd8, 5'd9, 5'd10, 5'd11:
               w_rdata = w_in_pad[{w_idx[1:0], 4'b0000} +: 16];
        5'd16, 5'd17, 5'd18, 5'd19:
               w_rdata = w_out_pad[{w_idx[1:0], 4'b0000} +: 16];
        default: w_rdata = 16'd0;
      endcase
    end
  end

  assign ebab_acknowledge = w_ack;
  assign ebab_read_data   = w_rdata;

endmodule

// File: tb/tb_rs_tick_ctrl.sv
module tb_rs_tick_ctrl;
  localparam int          N_IN  = 10;
  localparam int          N_OUT = 10;
  localparam logic [31:0] DIVR  = 32'd4999999;

  logic             i_clk = 1'b0, i_rst = 1'b1;
  logic [29:0]      ebab_address = '0;
  logic [1:0]       ebab_byte_enable = '0;
  logic             ebab_read = 1'b0, ebab_write = 1'b0;
  logic [15:0]      ebab_write_data = '0;
  logic             ebab_acknowledge;
  logic [15:0]      ebab_read_data;
  logic [N_IN-1:0]  i_switches = 10'h1A5;
  logic [N_OUT-1:0] i_rs_outputs = '0;
  logic [N_IN-1:0]  o_rs_inputs;
  logic             o_tick;

  rs_tick_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .DIV_RESET(DIVR)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .ebab_address(ebab_address), .ebab_byte_enable(ebab_byte_enable),
    .ebab_read(ebab_read), .ebab_write(ebab_write),
    .ebab_write_data(ebab_write_data), .ebab_acknowledge(ebab_acknowledge),
    .ebab_read_data(ebab_read_data), .i_switches(i_switches),
    .i_rs_outputs(i_rs_outputs), .o_rs_inputs(o_rs_inputs), .o_tick(o_tick));

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [4:0]  idx;
    logic [15:0] wd;
    logic [1:0]  be;
    logic [15:0] exp;
    string       nm;
  } vec_t;

  typedef struct {
    logic [15:0] exp;
    string       nm;
  } sb_t;

  sb_t         sbq[$];
  int          tq[$];
  int          n_vec = 0, n_err = 0;
  int          cyc = 0;
  int          last_ack_cyc = 0;
  logic [31:0] tick_total = 0;
  logic [N_IN-1:0] ri_hist[64];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: every ack pops one expected read-data entry.
  always @(negedge i_clk) begin
    sb_t e;
    ri_hist[cyc % 64] = o_rs_inputs;
    if (!i_rst && o_tick) begin
      tq.push_back(cyc);
      tick_total = tick_total + 1;
    end
    if (i_rst) tick_total = 0;
    if (!i_rst && ebab_acknowledge) begin
      if (sbq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL spurious_ack: got ack=1 want 0 (cyc %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk(e.nm, {48'd0, ebab_read_data}, {48'd0, e.exp});
      end
    end
  end

  function automatic vec_t mk(bit wr, bit rd, logic [4:0] idx, logic [15:0] wd,
                              logic [1:0] be, logic [15:0] exp, string nm);
    vec_t v;
    v.wr = wr; v.rd = rd; v.idx = idx; v.wd = wd; v.be = be; v.exp = exp; v.nm = nm;
    return v;
  endfunction

  // Starts just after a rising edge, ends just after a rising edge.
  task automatic xfer(input vec_t v);
    sb_t e;
    bit  got;
    e.exp = v.wr ? 16'h0000 : v.exp;
    e.nm  = v.nm;
    sbq.push_back(e);
    ebab_address     = {24'd0, v.idx, 1'b0};
    ebab_byte_enable = v.be;
    ebab_write_data  = v.wd;
    ebab_write       = v.wr;
    ebab_read        = v.rd;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge i_clk);
      if (ebab_acknowledge) begin got = 1'b1; last_ack_cyc = cyc; end
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: got no ack want ack", v.nm);
      void'(sbq.pop_back());
    end
    repeat (2) @(negedge i_clk);      // strobe still held: no second ack allowed
    @(posedge i_clk); #1;
    ebab_read = 1'b0; ebab_write = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [15:0] wd, input string nm);
    xfer(mk(1'b1, 1'b0, idx, wd, 2'b11, 16'h0, nm));
  endtask

  task automatic rd(input logic [4:0] idx, input logic [15:0] exp, input string nm);
    xfer(mk(1'b0, 1'b1, idx, 16'h0, 2'b00, exp, nm));
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  vec_t vt[$];
  int   land, cnt_after;
  bit   done;

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(negedge i_clk);
    chk("rst_tick", {63'd0, o_tick}, 64'd0);
    chk("rst_ack", {63'd0, ebab_acknowledge}, 64'd0);
    chk("rst_rdata", {48'd0, ebab_read_data}, 64'd0);
    chk("rst_rs_inputs", {54'd0, o_rs_inputs}, 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // ---------------- register map table ----------------
    vt.push_back(mk(0, 1, 5'd0,  16'h0,    2'b00, 16'h0000,    "rd_ctrl"));
    vt.push_back(mk(0, 1, 5'd1,  16'h0,    2'b00, 16'h0000,    "rd_status"));
    vt.push_back(mk(0, 1, 5'd2,  16'h0,    2'b00, DIVR[15:0],  "rd_div_lo"));
    vt.push_back(mk(0, 1, 5'd3,  16'h0,    2'b00, DIVR[31:16], "rd_div_hi"));
    vt.push_back(mk(0, 1, 5'd4,  16'h0,    2'b00, 16'h0000,    "rd_step"));
    vt.push_back(mk(0, 1, 5'd5,  16'h0,    2'b00, 16'h0000,    "rd_ticks_lo"));
    vt.push_back(mk(0, 1, 5'd6,  16'h0,    2'b00, 16'h0000,    "rd_ticks_hi"));
    vt.push_back(mk(0, 1, 5'd8,  16'h0,    2'b00, 16'h0000,    "rd_in0"));
    vt.push_back(mk(0, 1, 5'd16, 16'h0,    2'b00, 16'h0000,    "rd_out0"));
    vt.push_back(mk(0, 1, 5'd19, 16'h0,    2'b00, 16'h0000,    "rd_out3"));
    vt.push_back(mk(1, 0, 5'd20, 16'hFFFF, 2'b11, 16'h0000,    "wr_unmapped20"));
    vt.push_back(mk(0, 1, 5'd20, 16'h0,    2'b00, 16'h0000,    "rd_unmapped20"));
    vt.push_back(mk(1, 0, 5'd7,  16'hFFFF, 2'b11, 16'h0000,    "wr_unmapped7"));
    vt.push_back(mk(0, 1, 5'd7,  16'h0,    2'b00, 16'h0000,    "rd_unmapped7"));
    vt.push_back(mk(1, 0, 5'd2,  16'h1234, 2'b00, 16'h0000,    "wr_div_lo_be0"));
    vt.push_back(mk(0, 1, 5'd2,  16'h0,    2'b00, DIVR[15:0],  "rd_div_lo_be0"));
    vt.push_back(mk(1, 1, 5'd8,  16'h0301, 2'b11, 16'h0000,    "rdwr_in0"));
    vt.push_back(mk(0, 1, 5'd8,  16'h0,    2'b00, 16'h0301,    "rd_in0_after"));
    vt.push_back(mk(1, 0, 5'd9,  16'hFFFF, 2'b11, 16'h0000,    "wr_in1"));
    vt.push_back(mk(0, 1, 5'd9,  16'h0,    2'b00, 16'h0000,    "rd_in1_masked"));
    vt.push_back(mk(1, 0, 5'd8,  16'h0000, 2'b11, 16'h0000,    "wr_in0_clr"));
    foreach (vt[i]) xfer(vt[i]);

    // ---------------- free-run: DIV=3 for 20 cycles ----------------
    wr(5'd2, 16'd3, "div_lo3");
    wr(5'd3, 16'd0, "div_hi0");
    tq.delete();
    wr(5'd0, 16'h0001, "run_on");
    land = last_ack_cyc + 1;
    while (cyc != land + 18) begin @(posedge i_clk); #1; end
    wr(5'd0, 16'h0000, "run_off");
    wait_cyc(20);
    chk("fr_ticks", tq.size(), 5);
    if (tq.size() == 5) begin
      chk("fr_first", tq[0], land + 3);
      for (int i = 1; i < 5; i++) chk("fr_period", tq[i] - tq[i-1], 4);
    end
    rd(5'd5, 16'd5, "fr_ticks_lo");

    // ---------------- N-step: DIV=0, STEP_CNT=3 ----------------
    wr(5'd2, 16'd0, "div_lo0");
    tq.delete();
    wr(5'd4, 16'd3, "step3");
    land = last_ack_cyc + 1;
    wait_cyc(10);
    chk("ns_ticks", tq.size(), 3);
    if (tq.size() == 3) begin
      chk("ns_first", tq[0], land);
      chk("ns_consec", tq[2] - tq[0], 2);
    end
    rd(5'd4, 16'd0, "ns_step_cnt");
    rd(5'd1, 16'd0, "ns_status");

    // ---------------- STEP saturation and RUN freeze ----------------
    wr(5'd3, 16'h0100, "div_big");
    wr(5'd4, 16'hFFFE, "step_fffe");
    wr(5'd0, 16'h0002, "step_pulse1");
    rd(5'd4, 16'hFFFF, "step_inc");
    wr(5'd0, 16'h0002, "step_pulse2");
    rd(5'd4, 16'hFFFF, "step_sat");
    rd(5'd1, 16'h0003, "status_pending");
    wr(5'd0, 16'h0001, "run_on2");
    wr(5'd4, 16'd5, "step5");
    wr(5'd3, 16'h0000, "div_zero");
    rd(5'd4, 16'd5, "step_frozen");
    wr(5'd0, 16'h0003, "run_step");
    rd(5'd4, 16'd6, "step_add_run");
    rd(5'd0, 16'h0001, "ctrl_step_reads0");
    tq.delete();
    wr(5'd0, 16'h0000, "run_off2");
    land = last_ack_cyc + 1;
    wait_cyc(10);
    cnt_after = 0;
    foreach (tq[i]) if (tq[i] >= land) cnt_after++;
    chk("drain_ticks", cnt_after, 6);
    rd(5'd4, 16'd0, "drain_step");

    // ---------------- input path ----------------
    wr(5'd0, 16'h0004, "src_in");
    xfer(mk(1, 0, 5'd8, 16'h0155, 2'b01, 16'h0, "in0_lo"));
    xfer(mk(1, 0, 5'd8, 16'h0200, 2'b10, 16'h0, "in0_hi"));
    rd(5'd8, 16'h0255, "in0_merged");
    @(negedge i_clk);
    chk("rs_in_src1", {54'd0, o_rs_inputs}, 64'h255);
    @(posedge i_clk); #1;
    wr(5'd0, 16'h0000, "src_sw");
    land = last_ack_cyc + 1;
    chk("rs_in_last_in", {54'd0, ri_hist[land % 64]}, 64'h255);
    chk("rs_in_sw", {54'd0, ri_hist[(land + 1) % 64]}, 64'h1A5);
    land = cyc;
    i_switches = 10'h05A;
    wait_cyc(5);
    chk("sw_lag_old", {54'd0, ri_hist[(land + 2) % 64]}, 64'h1A5);
    chk("sw_lag_new", {54'd0, ri_hist[(land + 3) % 64]}, 64'h05A);

    // ---------------- output capture after a step ----------------
    i_rs_outputs = 10'h3FF;
    wr(5'd2, 16'd20, "div20");
    tq.delete();
    wr(5'd0, 16'h0002, "step_one");
    rd(5'd16, 16'h0000, "out0_before");
    wait_cyc(30);
    rd(5'd16, 16'h03FF, "out0_after");
    rd(5'd17, 16'h0000, "out1_masked");
    chk("out_step_ticks", tq.size(), 1);
    i_rs_outputs = 10'h0AA;
    wait_cyc(5);
    rd(5'd16, 16'h03FF, "out0_hold");

    // ---------------- TICKS carry into hi ----------------
    wr(5'd2, 16'd0, "div0_wrap");
    wr(5'd0, 16'h0001, "run_wrap");
    done = 1'b0;
    for (int i = 0; i < 70000 && !done; i++) begin
      @(negedge i_clk);
      if (tick_total >= 32'd65540) done = 1'b1;
    end
    chk("wrap_reached", {63'd0, done}, 64'd1);
    @(posedge i_clk); #1;
    wr(5'd0, 16'h0000, "run_wrap_off");
    rd(5'd5, tick_total[15:0], "wrap_ticks_lo");
    rd(5'd6, tick_total[31:16], "wrap_ticks_hi");
    chk("wrap_hi_is1", {48'd0, tick_total[31:16]}, 64'd1);

    // ---------------- reset mid-step and mid-transfer ----------------
    wr(5'd3, 16'h0100, "div_big2");
    wr(5'd4, 16'd3, "step3_pre_rst");
    begin
      sb_t e;
      e.exp = 16'h0003; e.nm = "status_pre_rst";
      sbq.push_back(e);
      ebab_address = {24'd0, 5'd1, 1'b0};
      ebab_read = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
        @(negedge i_clk);
        if (ebab_acknowledge) done = 1'b1;
      end
      chk("rst_mid_acked", {63'd0, done}, 64'd1);
      #1 i_rst = 1'b1;
      #1;
      chk("rst_mid_ack", {63'd0, ebab_acknowledge}, 64'd0);
      chk("rst_mid_rdata", {48'd0, ebab_read_data}, 64'd0);
      ebab_read = 1'b0;
      wait_cyc(2);
      i_rst = 1'b0;
      wait_cyc(1);
    end
    rd(5'd4, 16'd0, "rst_step");
    rd(5'd1, 16'd0, "rst_status");
    rd(5'd2, DIVR[15:0], "rst_div_lo");
    rd(5'd5, 16'd0, "rst_ticks_lo");
    rd(5'd8, 16'd0, "rst_in0");

    wait_cyc(3);
    if (sbq.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL sb_leftover: got %0d pending want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
